// File: rtl/instruction_memory_sync_if.sv
// Fetch and loader bus of the clocked LEGv8 instruction memory.
// The master side is the IF stage / program loader; the slave side is the memory.
interface instruction_memory_sync_if #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DEPTH   = 256
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic               fetch_req_valid;
    logic               fetch_req_ready;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               fetch_rsp_valid;
    logic               fetch_rsp_ready;
    logic [INSTR_W-1:0] fetch_rsp_instr;
    logic [1:0]         fetch_rsp_fault;
    logic               load_valid;
    logic [IDX_W:0]     load_widx;
    logic [31:0]        load_data;
    logic [3:0]         load_be;
    logic               load_err;

    modport master (
        output fetch_req_valid, fetch_addr, fetch_rsp_ready,
        output load_valid, load_widx, load_data, load_be,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_instr, fetch_rsp_fault, load_err
    );

    modport slave (
        input  fetch_req_valid, fetch_addr, fetch_rsp_ready,
        input  load_valid, load_widx, load_data, load_be,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_instr, fetch_rsp_fault, load_err
    );
endinterface

// File: rtl/instruction_memory_sync.sv
// Clocked LEGv8 instruction memory: word storage behind a valid/ready fetch port with a
// configurable read pipeline, a byte-enabled loader port and PC fault reporting.
module instruction_memory_sync #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned RD_LATENCY = 1
) (
    input logic                      clk,
    input logic                      reset_n,
    instruction_memory_sync_if.slave bus_io
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LAST  = RD_LATENCY - 1;

    if (INSTR_W != 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RD_LATENCY < 1 ||
        RD_LATENCY > 4 || ADDR_W <= IDX_W + 2) begin : g_bad_param
        $error("instruction_memory_sync: illegal parameter combination");
    end

    logic [INSTR_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]   rd_idx;
    logic [1:0]         rd_fault;
    logic [INSTR_W-1:0] rd_instr;
    logic               stall;

    logic               valid_q [RD_LATENCY];
    logic               valid_d [RD_LATENCY];
    logic [INSTR_W-1:0] instr_q [RD_LATENCY];
    logic [INSTR_W-1:0] instr_d [RD_LATENCY];
    logic [1:0]         fault_q [RD_LATENCY];
    logic [1:0]         fault_d [RD_LATENCY];
    logic               load_err_q;
    logic               load_err_d;

    assign rd_idx      = bus_io.fetch_addr[IDX_W+1:2];
    assign rd_fault[0] = |bus_io.fetch_addr[1:0];
    // No wrap-around: any address bit above the storage span is a fault, never an alias.
    assign rd_fault[1] = |bus_io.fetch_addr[ADDR_W-1:IDX_W+2];
    assign rd_instr    = (bus_io.fetch_req_valid && rd_fault == 2'b00) ? mem_q[rd_idx] : '0;

    assign stall                  = valid_q[LAST] & ~bus_io.fetch_rsp_ready;
    assign bus_io.fetch_req_ready = ~stall;
    assign bus_io.fetch_rsp_valid = valid_q[LAST];
    assign bus_io.fetch_rsp_instr = instr_q[LAST];
    assign bus_io.fetch_rsp_fault = fault_q[LAST];
    assign bus_io.load_err        = load_err_q;

    always_comb begin
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            valid_d[i] = valid_q[i];
            instr_d[i] = instr_q[i];
            fault_d[i] = fault_q[i];
        end
        if (!stall) begin
            valid_d[0] = bus_io.fetch_req_valid;
            instr_d[0] = rd_instr;
            fault_d[0] = bus_io.fetch_req_valid ? rd_fault : 2'b00;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                valid_d[i] = valid_q[i-1];
                instr_d[i] = instr_q[i-1];
                fault_d[i] = fault_q[i-1];
            end
        end
        load_err_d = bus_io.load_valid & bus_io.load_widx[IDX_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                valid_q[i] <= 1'b0;
                instr_q[i] <= '0;
                fault_q[i] <= 2'b00;
            end
            load_err_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
            load_err_q <= load_err_d;
        end
    end

    // Storage is not reset; the same-edge fetch above samples the pre-write contents.
    always_ff @(posedge clk) begin
        if (bus_io.load_valid && !bus_io.load_widx[IDX_W]) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_io.load_be[b]) begin
                    mem_q[bus_io.load_widx[IDX_W-1:0]][8*b +: 8] <= bus_io.load_data[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_instruction_memory_sync.sv
// Bench for instruction_memory_sync: two instances (RD_LATENCY 1 and 4) share one stimulus,
// one instance at a time is observed and checked against hand-computed vectors.
module tb_instruction_memory_sync;
    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned DEPTH   = 256;
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned LW      = IDX_W + 1;
    localparam int          NV      = 11;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] instr;
        logic [1:0]  fault;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic              req_valid = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              rsp_ready = 1'b1;
    logic              load_valid = 1'b0;
    logic [IDX_W:0]    load_widx = '0;
    logic [31:0]       load_data = '0;
    logic [3:0]        load_be = '0;
    logic              sel = 1'b0;
    int                lat = 1;
    int                checks = 0;
    int                errors = 0;
    vec_t              vecs [NV];

    instruction_memory_sync_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) if1 ();
    instruction_memory_sync_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) if4 ();

    assign if1.fetch_req_valid = req_valid;
    assign if1.fetch_addr      = req_addr;
    assign if1.fetch_rsp_ready = rsp_ready;
    assign if1.load_valid      = load_valid;
    assign if1.load_widx       = load_widx;
    assign if1.load_data       = load_data;
    assign if1.load_be         = load_be;
    assign if4.fetch_req_valid = req_valid;
    assign if4.fetch_addr      = req_addr;
    assign if4.fetch_rsp_ready = rsp_ready;
    assign if4.load_valid      = load_valid;
    assign if4.load_widx       = load_widx;
    assign if4.load_data       = load_data;
    assign if4.load_be         = load_be;

    instruction_memory_sync #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RD_LATENCY(1)
    ) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .bus_io(if1)
    );

    instruction_memory_sync #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RD_LATENCY(4)
    ) u_dut_l4 (
        .clk(clk), .reset_n(reset_n), .bus_io(if4)
    );

    logic        o_req_ready;
    logic        o_rsp_valid;
    logic [31:0] o_instr;
    logic [1:0]  o_fault;
    logic        o_load_err;
    assign o_req_ready = sel ? if4.fetch_req_ready : if1.fetch_req_ready;
    assign o_rsp_valid = sel ? if4.fetch_rsp_valid : if1.fetch_rsp_valid;
    assign o_instr     = sel ? if4.fetch_rsp_instr : if1.fetch_rsp_instr;
    assign o_fault     = sel ? if4.fetch_rsp_fault : if1.fetch_rsp_fault;
    assign o_load_err  = sel ? if4.load_err : if1.load_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL [lat=%0d] %s: got %0h expected %0h", lat, name, got, exp);
        end
    endtask

    function automatic logic [63:0] rsp_word();
        return 64'({o_rsp_valid, o_fault, o_instr});
    endfunction

    function automatic logic [63:0] exp_word(input logic [31:0] i, input logic [1:0] f);
        return 64'({1'b1, f, i});
    endfunction

    task automatic load(input logic [IDX_W:0] widx, input logic [31:0] d, input logic [3:0] be);
        load_valid = 1'b1;
        load_widx  = widx;
        load_data  = d;
        load_be    = be;
        tick();
        load_valid = 1'b0;
    endtask

    // Single fetch with any pending load applied on the same acceptance edge.
    task automatic fetch_one(input string name, input logic [63:0] addr,
                             input logic [31:0] exp_i, input logic [1:0] exp_f);
        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = 1'b1;
        tick();
        req_valid  = 1'b0;
        load_valid = 1'b0;
        for (int i = 1; i < lat; i++) begin
            check({name, " early"}, 64'(o_rsp_valid), 64'd0);
            tick();
        end
        check(name, rsp_word(), exp_word(exp_i, exp_f));
        tick();
        check({name, " once"}, 64'(o_rsp_valid), 64'd0);
    endtask

    task automatic do_reset();
        req_valid  = 1'b0;
        load_valid = 1'b0;
        rsp_ready  = 1'b1;
        reset_n    = 1'b0;
        repeat (3) tick();
        check("reset rsp_valid", 64'(o_rsp_valid), 64'd0);
        check("reset instr", 64'(o_instr), 64'd0);
        check("reset fault", 64'(o_fault), 64'd0);
        check("reset load_err", 64'(o_load_err), 64'd0);
        reset_n = 1'b1;
        tick();
        check("reset req_ready", 64'(o_req_ready), 64'd1);
    endtask

    task automatic run_stream();
        int k;
        for (int c = 0; c < NV + lat + 1; c++) begin
            req_valid = (c < NV);
            req_addr  = (c < NV) ? vecs[c].addr : 64'd0;
            rsp_ready = 1'b1;
            tick();
            k = c - lat + 1;
            if (k >= 0 && k < NV) begin
                check($sformatf("stream %0d", k), rsp_word(), exp_word(vecs[k].instr, vecs[k].fault));
            end else begin
                check("stream idle", 64'(o_rsp_valid), 64'd0);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic run_backpressure();
        int issued = 0;
        int got = 0;
        int exp_q[$];
        for (int c = 0; c < 20; c++) begin
            rsp_ready = (c >= 10);
            req_valid = (issued < 3);
            req_addr  = vecs[issued].addr;
            #1;
            if (o_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("bp spurious rsp", 64'(o_rsp_valid), 64'd0);
                end else begin
                    check("bp rsp", rsp_word(),
                          exp_word(vecs[exp_q[0]].instr, vecs[exp_q[0]].fault));
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
                if (!rsp_ready) check("bp req_ready", 64'(o_req_ready), 64'd0);
            end
            if (req_valid && o_req_ready) begin
                exp_q.push_back(issued);
                issued++;
            end
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check("bp issued", 64'(issued), 64'd3);
        check("bp delivered", 64'(got), 64'd3);
        check("bp drained", 64'(o_rsp_valid), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{64'h0, 32'hF2BFD749, 2'b00};
        vecs[1]  = '{64'h4, 32'h8B020020, 2'b00};
        vecs[2]  = '{64'h8, 32'hD2800009, 2'b00};
        vecs[3]  = '{64'hC, 32'h00000000, 2'b00};
        vecs[4]  = '{64'h3FC, 32'hCAFEBABE, 2'b00};
        vecs[5]  = '{64'h6, 32'h0, 2'b01};
        vecs[6]  = '{64'h400, 32'h0, 2'b10};
        vecs[7]  = '{64'h402, 32'h0, 2'b11};
        vecs[8]  = '{64'h8000_0000_0000_0000, 32'h0, 2'b10};
        vecs[9]  = '{64'h3FD, 32'h0, 2'b01};
        vecs[10] = '{64'h10_0000_0004, 32'h0, 2'b10};

        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            lat = (s == 1) ? 4 : 1;
            do_reset();

            load(LW'(0), 32'hF2BFD749, 4'hF);
            load(LW'(1), 32'h8B020020, 4'hF);
            load(LW'(2), 32'hD2800009, 4'hF);
            load(LW'(3), 32'h00000000, 4'hF);
            load(LW'(255), 32'hCAFEBABE, 4'hF);
            check("in-range load_err", 64'(o_load_err), 64'd0);

            run_stream();
            run_backpressure();

            // Same-edge load and fetch: old word first, merged word afterwards.
            load_valid = 1'b1;
            load_widx  = LW'(1);
            load_data  = 32'h11223344;
            load_be    = 4'b0011;
            fetch_one("rbw old", 64'h4, 32'h8B020020, 2'b00);
            fetch_one("rbw new", 64'h4, 32'h8B023344, 2'b00);

            load(LW'(2), 32'hFFFFFFFF, 4'h0);
            check("be0 load_err", 64'(o_load_err), 64'd0);
            fetch_one("be0 no-op", 64'h8, 32'hD2800009, 2'b00);

            load(LW'(DEPTH), 32'hDEADBEEF, 4'hF);
            check("oor load_err pulse", 64'(o_load_err), 64'd1);
            tick();
            check("oor load_err clear", 64'(o_load_err), 64'd0);
            fetch_one("oor no write", 64'h0, 32'hF2BFD749, 2'b00);

            // Reset with two fetches in flight.
            req_valid = 1'b1;
            req_addr  = 64'h0;
            rsp_ready = 1'b1;
            tick();
            req_addr = 64'h8;
            tick();
            req_valid = 1'b0;
            check("pre-reset rsp_valid", 64'(o_rsp_valid), (lat == 1) ? 64'd1 : 64'd0);
            reset_n = 1'b0;
            #1;
            check("async reset rsp_valid", 64'(o_rsp_valid), 64'd0);
            tick();
            reset_n = 1'b1;
            for (int i = 0; i < lat + 2; i++) begin
                tick();
                check("post-reset no stale rsp", 64'(o_rsp_valid), 64'd0);
            end
            check("post-reset req_ready", 64'(o_req_ready), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
